// File: rtl/if_prefetch.sv
// if_prefetch: instruction fetch stage with in-order SRAM requests, redirect cancel and a small instruction buffer.
module if_prefetch #(
  parameter logic [31:0] RESET_PC  = 32'hbfc00000,
  parameter int          BUF_DEPTH = 4,
  parameter int          MAX_OUTST = BUF_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        ex_flush,
  input  logic [31:0] ex_pc,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_inst,
  output logic [31:0] fs_pc,
  output logic        fs_ex_adel
);
  localparam int BW = $clog2(BUF_DEPTH);
  localparam int CW = BW + 1;
  localparam int PW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(BUF_DEPTH);
  localparam logic [CW-1:0] MAX_W   = CW'(MAX_OUTST);
  localparam logic [PW-1:0] PLAST   = PW'(MAX_OUTST - 1);

  logic [31:0]   pc_q, pc_d;
  logic [BW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, infl_q, infl_d, cancel_q, cancel_d;
  logic [PW-1:0] pwr_q, pwr_d, prd_q, prd_d;
  logic          stall_q, stall_d;
  logic [31:0]   pc_buf [BUF_DEPTH];
  logic [31:0]   inst_buf [BUF_DEPTH];
  logic          adel_buf [BUF_DEPTH];
  logic [31:0]   pend_q [MAX_OUTST];

  logic          redirect, dok, accept, enq_data, enq_adel, enq, deq;
  logic [31:0]   target;
  logic [CW:0]   occ;

  always_comb begin
    redirect       = ex_flush | br_valid;
    target         = ex_flush ? ex_pc : br_target;
    dok            = inst_sram_data_ok && infl_q != '0;
    // slots already promised: buffered entries plus responses that will still be kept
    occ            = {1'b0, count_q} + {1'b0, infl_q} - {1'b0, cancel_q};
    inst_sram_req  = !reset && !redirect && pc_q[1:0] == 2'b00 && infl_q < MAX_W && occ < DEPTH_W;
    accept         = inst_sram_req && inst_sram_addr_ok;
    enq_data       = !reset && dok && cancel_q == '0 && !redirect;
    enq_adel       = !reset && !redirect && !stall_q && pc_q[1:0] != 2'b00 && infl_q == cancel_q && occ < DEPTH_W;
    enq            = enq_data | enq_adel;
    fs_to_ds_valid = !reset && count_q != '0 && !redirect;
    deq            = fs_to_ds_valid && ds_allowin;
    pc_d           = redirect ? target : accept ? pc_q + 32'd4 : pc_q;
    infl_d         = infl_q + CW'(accept) - CW'(dok);
    cancel_d       = redirect ? infl_q - CW'(dok) : cancel_q - CW'(dok && cancel_q != '0);
    count_d        = redirect ? '0 : count_q + CW'(enq) - CW'(deq);
    head_d         = redirect ? '0 : head_q + BW'(deq);
    tail_d         = redirect ? '0 : tail_q + BW'(enq);
    stall_d        = !redirect && (stall_q || enq_adel);
    pwr_d          = accept ? (pwr_q == PLAST ? '0 : pwr_q + PW'(1)) : pwr_q;
    prd_d          = dok ? (prd_q == PLAST ? '0 : prd_q + PW'(1)) : prd_q;
    inst_sram_addr = pc_q;
    fs_pc          = pc_buf[head_q];
    fs_inst        = inst_buf[head_q];
    fs_ex_adel     = fs_to_ds_valid && adel_buf[head_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      infl_q   <= '0;
      cancel_q <= '0;
      pwr_q    <= '0;
      prd_q    <= '0;
      stall_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      infl_q   <= infl_d;
      cancel_q <= cancel_d;
      pwr_q    <= pwr_d;
      prd_q    <= prd_d;
      stall_q  <= stall_d;
    end
    if (accept) pend_q[pwr_q] <= pc_q;
    if (enq) begin
      pc_buf[tail_q]   <= enq_adel ? pc_q : pend_q[prd_q];
      inst_buf[tail_q] <= enq_adel ? 32'h0 : inst_sram_rdata;
      adel_buf[tail_q] <= enq_adel;
    end
  end
endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hbfc00000; first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 4; instruction buffer entries; power of two, 2..16.
REQ-003 SHALL have parameter MAX_OUTST, default BUF_DEPTH; maximum in-flight SRAM requests, at most BUF_DEPTH.
REQ-004 clk  in  1  clock; all state updates on posedge clk.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 ds_allowin  in  1  decode can accept an instruction this cycle.
REQ-007 br_valid  in  1  branch redirect request.
REQ-008 br_target  in  32  branch redirect address.
REQ-009 ex_flush  in  1  exception/ERET redirect request.
REQ-010 ex_pc  in  32  exception redirect address.
REQ-011 inst_sram_req  out  1  fetch request valid.
REQ-012 inst_sram_addr  out  32  fetch address.
REQ-013 inst_sram_addr_ok  in  1  request accepted this cycle.
REQ-014 inst_sram_data_ok  in  1  read data returned this cycle, in request order.
REQ-015 inst_sram_rdata  in  32  returned instruction.
REQ-016 fs_to_ds_valid  out  1  buffer head valid toward decode.
REQ-017 fs_inst  out  32  head instruction; 32'h0 when head is an exception entry.
REQ-018 fs_pc  out  32  head PC.
REQ-019 fs_ex_adel  out  1  head entry carries an instruction-fetch AdEL.

Function
REQ-020 State SHALL be: fetch PC; circular buffer of BUF_DEPTH entries {pc, inst, adel}; inflight counter; cancel counter; pending-PC FIFO of MAX_OUTST entries holding the PC of each accepted request.
REQ-021 inst_sram_req SHALL be 1 only when: not reset; no redirect this cycle; pc[1:0]==0; inflight<MAX_OUTST; (count + inflight - cancel) < BUF_DEPTH.
REQ-022 inst_sram_addr SHALL equal fetch PC; a request is accepted on req && addr_ok, which pushes PC to the pending FIFO, increments inflight, and advances PC by 4 (32-bit wrap).
REQ-023 On data_ok, inflight SHALL decrement and the pending FIFO SHALL pop.
REQ-024 If cancel>0, cancel SHALL decrement and the data SHALL be dropped; otherwise {popped pc, rdata, 0} SHALL be enqueued.
REQ-025 If pc[1:0]!=0, inflight==cancel and the buffer is not full, one entry {pc, 32'h0, 1} SHALL be enqueued, and fetch SHALL stall until a redirect; no SRAM request SHALL be issued for a misaligned PC.
REQ-026 fs_to_ds_valid SHALL equal buffer not empty and no redirect this cycle; dequeue SHALL occur on fs_to_ds_valid && ds_allowin.
REQ-027 Simultaneous enqueue and dequeue SHALL be allowed at any count, including full, with count unchanged.
REQ-028 Redirect SHALL be ex_flush || br_valid; ex_flush SHALL have priority, and br_target is ignored in that cycle.
REQ-029 On redirect: PC<=target; buffer SHALL be emptied; cancel<=inflight-data_ok; data returned in the redirect cycle SHALL be dropped; misaligned stall SHALL clear.
REQ-030 The redirect target SHALL be fetched only after the redirect cycle; responses to it SHALL be delivered only after all cancelled responses have drained.
REQ-031 Back-to-back redirects SHALL accumulate correctly; cancel never exceeds inflight.
REQ-032 data_ok with inflight==0 is illegal; the design SHALL NOT change state for it.

Reset
REQ-033 During reset: PC<=RESET_PC; buffer, inflight and cancel <=0; stall cleared.
REQ-034 During reset, outputs SHALL be: inst_sram_req 0, fs_to_ds_valid 0, fs_ex_adel 0.
REQ-035 Reset asserted mid-transaction SHALL discard all in-flight requests; data_ok arriving after reset deassertion is not expected (the SRAM is reset together with this block).

Verification
REQ-036 Reset release, 1-cycle-latency SRAM, ds_allowin=1 -> addrs bfc00000, bfc00004, ...; fs_pc follows in order, one instruction per cycle.
REQ-037 ds_allowin=0 for 10 cycles, BUF_DEPTH=4 -> exactly 4 accepted requests; req then held 0; no entry lost; order preserved on release.
REQ-038 br_valid to 0x80001000 with 3 requests in flight -> 3 responses dropped; next fs_pc=0x80001000; no stale PC delivered.
REQ-039 ex_flush=1 (ex_pc 0xbfc00380) and br_valid=1 in the same cycle with data_ok=1 -> that data is dropped; next fetch address 0xbfc00380.
REQ-040 br_target=0x80000002 -> no SRAM request; one entry with fs_pc=0x80000002, fs_ex_adel=1, fs_inst=0; stall held until ex_flush.
REQ-041 Random addr_ok/data_ok latency 0-5 cycles, random ds_allowin and redirects, 10k cycles -> scoreboard: delivered PCs are sequential from each redirect target; inflight<=MAX_OUTST always.
